// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Owns the instruction-fetch program counter in front of the instruction ROM
// interface. The PC advances by 4 for every accepted fetch. It holds while the
// ROM reports an incomplete fetch or the pipeline stalls. Branch/jump
// redirects from ID are applied immediately when there is no stall. A redirect
// that arrives during a stall is buffered and applied on the first stall-free
// edge. The block also counts stall cycles in a saturating counter for
// performance debug.
//
// Optional feature (compile-time macro): PC_EXC_REDIRECT_EN
//   When defined, the exc_flag port exists. An exception pulse redirects the
//   PC to EXC_VECTOR and discards any buffered redirect, even during a stall.
//   When undefined, exc_flag and EXC_VECTOR are absent.
//
// Parameters
//   EXC_VECTOR            exception entry address (only with the macro)
//   RESET_PC              PC loaded on reset; also the first address fetched
//
// Ports
//   clk                   in   1   system clock, rising-edge
//   rst                   in   1   synchronous, active-high reset
//   stall_pc_flush_if_id  in   1   ROM interface: current fetch not complete
//   stall_pipe            in   1   downstream hazard stall
//   branch_flag           in   1   ID-stage redirect request (pulse)
//   branch_target         in  32   redirect address, bits [1:0] ignored
//   exc_flag              in   1   exception redirect pulse (macro only)
//   inst_address          out 32   registered fetch PC to the ROM interface
//   if_valid              out  1   instruction at inst_address accepted now
//   redirect_pending      out  1   a buffered redirect awaits end of stall
//   fetch_stall_cnt       out 16   saturating count of stall cycles
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
`ifdef PC_EXC_REDIRECT_EN
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
`endif
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_pc_flush_if_id,
    input  logic        stall_pipe,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
`ifdef PC_EXC_REDIRECT_EN
    input  logic        exc_flag,
`endif
    output logic [31:0] inst_address,
    output logic        if_valid,
    output logic        redirect_pending,
    output logic [15:0] fetch_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        stall;
    logic        active;
    logic [31:0] tgt_aligned;
    logic        unused_tgt_lsbs;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end
        return v + 16'd1;
    endfunction

    assign stall           = stall_pc_flush_if_id | stall_pipe;
    assign active          = (state_q != ST_IDLE);
    assign tgt_aligned     = {branch_target[31:2], 2'b00};
    assign unused_tgt_lsbs = ^branch_target[1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        stall_cnt_d   = stall_cnt_q;

        if (!active) begin
            // Leaving IDLE does not move the PC: RESET_PC is fetched first.
            state_d = ST_RUN;
        end else begin
            // RUN and WAIT share the same exit condition.
            state_d = stall_pc_flush_if_id ? ST_WAIT : ST_RUN;

            if (stall) begin
                stall_cnt_d = sat_inc16(stall_cnt_q);
            end

`ifdef PC_EXC_REDIRECT_EN
            if (exc_flag) begin
                pc_d         = EXC_VECTOR;
                pend_valid_d = 1'b0;
            end else
`endif
            if (stall) begin
                // PC holds; remember the latest redirect for later.
                if (branch_flag) begin
                    pend_target_d = tgt_aligned;
                    pend_valid_d  = 1'b1;
                end
            end else if (branch_flag) begin
                // A live redirect supersedes any older buffered one.
                pc_d         = tgt_aligned;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0000_0000;
            stall_cnt_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign inst_address     = pc_q;
    assign redirect_pending = pend_valid_q;
    assign fetch_stall_cnt  = stall_cnt_q;
    assign if_valid         = active & ~stall_pc_flush_if_id & ~stall_pipe;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pc_fetch_ctrl. It runs directed scenarios and a randomized
// phase. A behavioural reference model tracks the expected fetch PC, the
// buffered redirect and the stall count. Outputs are checked every cycle.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    logic        clk;
    logic        rst;
    logic        spf;
    logic        sp;
    logic        bf;
    logic [31:0] bt;
    logic        exc;
    logic [31:0] inst_address;
    logic        if_valid;
    logic        redirect_pending;
    logic [15:0] fetch_stall_cnt;

    int n_vec;
    int n_err;

    // Reference model state
    bit          m_running;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_tgt;
    int          m_cnt;

    pc_fetch_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall_pc_flush_if_id (spf),
        .stall_pipe           (sp),
        .branch_flag          (bf),
        .branch_target        (bt),
`ifdef PC_EXC_REDIRECT_EN
        .exc_flag             (exc),
`endif
        .inst_address         (inst_address),
        .if_valid             (if_valid),
        .redirect_pending     (redirect_pending),
        .fetch_stall_cnt      (fetch_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one clock edge with the currently applied inputs.
    task automatic model_edge();
        logic s;
        s = spf | sp;
        if (rst) begin
            m_running  = 1'b0;
            m_pc       = RESET_PC;
            m_pend     = 1'b0;
            m_pend_tgt = 32'h0;
            m_cnt      = 0;
        end else if (!m_running) begin
            m_running = 1'b1;
        end else begin
            if (s) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
`ifdef PC_EXC_REDIRECT_EN
            if (exc) begin
                m_pc   = EXC_VECTOR;
                m_pend = 1'b0;
            end else
`endif
            if (s) begin
                if (bf) begin
                    m_pend     = 1'b1;
                    m_pend_tgt = bt & 32'hFFFF_FFFC;
                end
            end else if (bf) begin
                m_pc   = bt & 32'hFFFF_FFFC;
                m_pend = 1'b0;
            end else if (m_pend) begin
                m_pc   = m_pend_tgt;
                m_pend = 1'b0;
            end else begin
                m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
            end
        end
    endtask

    // Apply inputs for one cycle, check if_valid, clock, then check state.
    task automatic step(input logic r, input logic a, input logic b, input logic f,
                        input logic [31:0] t, input logic e);
        @(negedge clk);
        rst = r; spf = a; sp = b; bf = f; bt = t; exc = e;
        #1;
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_running & ~a & ~b});
        @(posedge clk);
        model_edge();
        #1;
        chk("inst_address", inst_address, m_pc);
        chk("redirect_pending", {31'b0, redirect_pending}, {31'b0, m_pend});
        chk("fetch_stall_cnt", {16'b0, fetch_stall_cnt}, 32'(m_cnt));
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_running = 1'b0; m_pc = RESET_PC; m_pend = 1'b0; m_pend_tgt = 32'h0; m_cnt = 0;
        rst = 1'b1; spf = 1'b0; sp = 1'b0; bf = 1'b0; bt = 32'h0; exc = 1'b0;

        // Reset then run
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_pc", inst_address, 32'hBFC0_0000);
        chk("rst_pend", {31'b0, redirect_pending}, 32'h0);
        chk("rst_cnt", {16'b0, fetch_stall_cnt}, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        chk("first_run_pc", inst_address, 32'hBFC0_0000);
        step(0, 0, 0, 0, 0, 0);
        chk("run_pc1", inst_address, 32'hBFC0_0004);
        step(0, 0, 0, 0, 0, 0);
        chk("run_pc2", inst_address, 32'hBFC0_0008);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("pc_before_br", inst_address, 32'hBFC0_0010);

        // Branch, no stall; low target bits dropped
        step(0, 0, 0, 1, 32'hBFC0_0103, 0);
        chk("br_nostall_pc", inst_address, 32'hBFC0_0100);
        chk("br_nostall_pend", {31'b0, redirect_pending}, 32'h0);

        // Branch during ROM stall, buffered then applied
        step(0, 1, 0, 1, 32'hBFC0_0200, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("stall_pc_held", inst_address, 32'hBFC0_0100);
        chk("stall_pend", {31'b0, redirect_pending}, 32'h1);
        step(0, 0, 0, 0, 0, 0);
        chk("buf_redirect_pc", inst_address, 32'hBFC0_0200);
        chk("buf_redirect_pend", {31'b0, redirect_pending}, 32'h0);
        chk("stall_cnt3", {16'b0, fetch_stall_cnt}, 32'd3);

        // Latest-wins overwrite of a buffered redirect via pipe stall
        step(0, 0, 1, 1, 32'h0000_1000, 0);
        step(0, 0, 1, 1, 32'h0000_2002, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("latest_wins_pc", inst_address, 32'h0000_2000);

`ifdef PC_EXC_REDIRECT_EN
        // Exception overrides a pending redirect during stall
        step(0, 1, 0, 1, 32'h0000_3000, 0);
        step(0, 1, 0, 0, 0, 1);
        chk("exc_pc", inst_address, 32'hBFC0_0380);
        chk("exc_pend", {31'b0, redirect_pending}, 32'h0);
        step(0, 0, 0, 0, 0, 0);
`endif

        // Wrap-around of the PC
        step(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        chk("wrap_pre", inst_address, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap_post", inst_address, 32'h0000_0000);

        // Randomized phase
        for (int i = 0; i < 2000; i++) begin
            logic r, a, b, f, e;
            logic [31:0] t;
            r = ($urandom_range(63) == 0);
            a = ($urandom_range(3) == 0);
            b = ($urandom_range(5) == 0);
            f = ($urandom_range(4) == 0);
            t = $urandom;
`ifdef PC_EXC_REDIRECT_EN
            e = ($urandom_range(15) == 0);
`else
            e = 1'b0;
`endif
            step(r, a, b, f, t, e);
        end

        // Reset mid-stall with a pending redirect
        step(0, 1, 0, 1, 32'h0000_4000, 0);
        step(1, 1, 0, 1, 32'h0000_5000, 1);
        chk("rst_mid_pc", inst_address, 32'hBFC0_0000);
        chk("rst_mid_pend", {31'b0, redirect_pending}, 32'h0);
        chk("rst_mid_cnt", {16'b0, fetch_stall_cnt}, 32'h0);

        // Counter saturation under a long stall
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++) begin
            step(0, 0, 1, 0, 0, 0);
        end
        chk("cnt_sat", {16'b0, fetch_stall_cnt}, 32'h0000_FFFF);
        chk("cnt_sat_pc", inst_address, 32'hBFC0_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch-sequencing block sitting directly upstream of the instruction ROM interface. It owns the fetch PC, advances it by 4 per accepted fetch, and holds it while the ROM reports "instruction not yet valid" or the pipeline stalls. It applies branch/jump redirects from ID, buffering any redirect that arrives during a stall. It also drives a valid flag toward the IF/ID register and a saturating fetch-stall counter for performance debug.

## Interface
- RESET_PC, 32'hBFC0_0000, PC loaded on reset and first address fetched.
- EXC_VECTOR, 32'hBFC0_0380, exception entry address (used only with PC_EXC_REDIRECT_EN).
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_pc_flush_if_id  in  1  from ROM interface: 1 = current fetch not complete.
- stall_pipe  in  1  downstream hazard stall: hold PC, fetch result not consumed.
- branch_flag  in  1  ID-stage redirect request, one-cycle pulse.
- branch_target  in  32  redirect address. Bits [1:0] ignored and forced to 00.
- exc_flag  in  1  exception redirect pulse (present only with PC_EXC_REDIRECT_EN).
- inst_address  out  32  current fetch PC to the ROM interface (registered).
- if_valid  out  1  1 = instruction at inst_address is valid and accepted this cycle.
- redirect_pending  out  1  a buffered redirect is waiting for the stall to clear.
- fetch_stall_cnt  out  16  count of stall cycles in RUN/WAIT, saturating.

## Operation
- States: IDLE, RUN, WAIT (2-bit encoded).
  - IDLE: entered on rst. inst_address = RESET_PC, if_valid = 0. Goes to RUN on the first cycle with rst = 0. PC is unchanged on that transition.
  - RUN: from RUN, go to WAIT if stall_pc_flush_if_id = 1, otherwise stay in RUN.
  - WAIT: from WAIT, go to RUN when stall_pc_flush_if_id = 0.
- stall = stall_pc_flush_if_id | stall_pipe. Valid only in RUN/WAIT.
- if_valid = (state != IDLE) & ~stall_pc_flush_if_id & ~stall_pipe. Combinational from registered state and inputs.
- Next-PC priority, evaluated each edge when state != IDLE:
  - 1: exc_flag → EXC_VECTOR. Clears any pending redirect. Applies even during stall.
  - 2: when stall = 1, PC holds. A live branch_flag is latched: pend_target ← {branch_target[31:2],2'b00}, pend_valid ← 1.
  - 3: live branch_flag with stall = 0 → PC ← target. Also clears pend_valid.
  - 4: pend_valid with stall = 0 → PC ← pend_target, pend_valid ← 0.
  - 5: otherwise PC ← PC + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- A second branch_flag while pend_valid = 1 overwrites pend_target (latest wins).
- Delay slot: branch resolves in ID while the delay slot is in IF, so the redirect replaces the PC + 4 after the slot. No extra bubble is inserted.
- redirect_pending = pend_valid.
- fetch_stall_cnt increments by 1 on every edge where state != IDLE and stall = 1. It holds at 16'hFFFF.

## Timing
- Reset (rst = 1 at an edge): inst_address = RESET_PC, state = IDLE, pend_valid = 0, pend_target = 0, fetch_stall_cnt = 0. if_valid = 0 and redirect_pending = 0.
- rst asserted mid-operation overrides every other input on that edge, including a pending redirect and exc_flag.
- Latency: branch_flag sampled at edge N with no stall → inst_address = target after edge N.
- Buffered redirect: applied on the first edge with stall = 0 → target visible one cycle after the stall clears. No intermediate PC + 4 is fetched.
- Stall held for K edges → inst_address constant for those K edges. fetch_stall_cnt rises by K.
- inst_address changes only on clk edges. The ROM interface sees a stable address for the whole cycle.

## Configuration
- PC_EXC_REDIRECT_EN defined: exc_flag port and priority-1 path exist. Exception redirects to EXC_VECTOR and flushes pend_valid.
- PC_EXC_REDIRECT_EN undefined: exc_flag port is absent and EXC_VECTOR is unused. Priority starts at the stall rule.

## Test plan
- Reset then run: rst high 2 cycles, then low, no stalls → inst_address = BFC00000 for IDLE and the first RUN cycle, then BFC00004, BFC00008. if_valid = 1 from the first RUN cycle.
- Branch, no stall: branch_flag = 1, target = 0xBFC00103 while PC = BFC00010 → next inst_address = BFC00100. pend_valid stays 0.
- Branch during ROM stall: stall_pc_flush_if_id = 1 for 3 cycles, branch_flag pulse (target BFC00200) in cycle 1 → PC held, redirect_pending = 1. First cycle after the stall clears shows inst_address = BFC00200, redirect_pending = 0. fetch_stall_cnt = 3.
- Exception priority (macro on): pend_valid = 1 with stall active, exc_flag = 1 → inst_address = BFC00380 next edge, redirect_pending = 0.
- Wrap and saturation: PC forced to FFFFFFFC via branch → next 00000000. Stall held 70000 cycles → fetch_stall_cnt = FFFF.
- Reset mid-stall: pend_valid = 1, rst = 1 → inst_address = BFC00000, redirect_pending = 0, counter = 0.
